// File: rtl/fcvt_if.sv
// Handshake/data bundle for the iterative int32 <-> float32 converter.
// master = requester, slave = converter.
interface fcvt_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  flags;

  modport master (output start, op, a, input busy, done, result, flags);
  modport slave  (input start, op, a, output busy, done, result, flags);
endinterface

// File: rtl/fcvt_iter.sv
// Iterative converter: signed int32 -> float32 (op=0) and float32 -> signed int32 (op=1),
// one bit of normalisation/alignment shift per cycle, round-to-nearest-even.
module fcvt_iter (
  input  logic  clk,
  input  logic  rst,
  fcvt_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  flags_q, flags_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  fe_s;
  logic [22:0] frac_s;
  logic        i2f_inc_s;
  logic [23:0] i2f_sum_s;
  logic        f2i_inc_s;
  logic [31:0] f2i_sum_s;

  assign fe_s      = a_q[30:23];
  assign frac_s    = a_q[22:0];
  assign i2f_inc_s = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  assign i2f_sum_s = {1'b0, mag_q[30:8]} + {23'd0, i2f_inc_s};
  // Right-aligned magnitude is below 2^31, so the rounded sum cannot wrap 32 bits.
  assign f2i_inc_s = guard_q & (sticky_q | mag_q[0]);
  assign f2i_sum_s = mag_q + {31'd0, f2i_inc_s};

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    op_d     = op_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PREP;
          a_d     = bus.a;
          op_d    = bus.op;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        sign_d   = a_q[31];
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        if (!op_q) begin
          mag_d = a_q[31] ? (32'd0 - a_q) : a_q;
          exp_d = 8'd158;
          if (a_q == 32'd0) begin
            result_d = 32'd0;
            flags_d  = 2'b00;
            state_d  = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else if (fe_s == 8'd255) begin
          state_d = S_DONE;
          if (frac_s != 23'd0) begin
            result_d = 32'h7FFF_FFFF;
            flags_d  = 2'b11;
          end else begin
            result_d = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            flags_d  = 2'b01;
          end
        end else if (fe_s < 8'd126) begin
          state_d  = S_DONE;
          result_d = 32'd0;
          flags_d  = (a_q[30:0] != 31'd0) ? 2'b10 : 2'b00;
        end else if (a_q == 32'hCF00_0000) begin
          state_d  = S_DONE;
          result_d = 32'h8000_0000;
          flags_d  = 2'b00;
        end else if (fe_s >= 8'd158) begin
          state_d  = S_DONE;
          result_d = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          flags_d  = 2'b01;
        end else begin
          state_d = S_SHIFT;
          mag_d   = {8'd0, 1'b1, frac_s};
          if (fe_s <= 8'd150) begin
            left_d = 1'b0;
            cnt_d  = 5'(8'd150 - fe_s);
          end else begin
            left_d = 1'b1;
            cnt_d  = 5'(fe_s - 8'd150);
          end
        end
      end
      S_SHIFT: begin
        if (!op_q) begin
          if (mag_q[31]) begin
            state_d = S_ROUND;
          end else begin
            mag_d = {mag_q[30:0], 1'b0};
            exp_d = exp_q - 8'd1;
          end
        end else if (cnt_q == 5'd0) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (left_q) begin
            mag_d = {mag_q[30:0], 1'b0};
          end else begin
            mag_d    = {1'b0, mag_q[31:1]};
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
          end
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (!op_q) begin
          result_d = {sign_q, exp_q + {7'd0, i2f_sum_s[23]}, i2f_sum_s[22:0]};
          flags_d  = 2'b00;
        end else if (!sign_q && f2i_sum_s[31]) begin
          result_d = 32'h7FFF_FFFF;
          flags_d  = 2'b01;
        end else begin
          result_d = sign_q ? (32'd0 - f2i_sum_s) : f2i_sum_s;
          flags_d  = 2'b00;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_PREP) || (state_d == S_SHIFT) || (state_d == S_ROUND);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
      exp_q    <= 8'd0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= 32'd0;
      flags_q  <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_fcvt_iter.sv
// Directed self-checking bench for fcvt_iter; expected values are hand-computed.
module tb_fcvt_iter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fcvt_if bus ();

  fcvt_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = index of the rising edge (after the start-sampling edge) that samples done high; -1 on timeout.
  task automatic run_conv(input logic op_v, input logic [31:0] a_v,
                          output logic [31:0] res, output logic [1:0] flg, output int lat);
    int n;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.a     = a_v;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    res = bus.result;
    flg = bus.flags;
    lat = got ? n + 1 : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.flags !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", bus.flags); end
    rst = 1'b0;
  endtask

  task automatic test_i2f();
    logic [31:0] vin  [0:6];
    logic [31:0] vexp [0:6];
    int          vlat [0:6];
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
    vin  = '{32'h00000001, 32'h80000000, 32'h01000001, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vexp = '{32'h3F800000, 32'hCF000000, 32'h4B800000, 32'hC0400000, 32'h4F000000, 32'h00000000, 32'hBF800000};
    vlat = '{35, 4, 11, 34, 5, 2, 35};
    for (int i = 0; i < 7; i++) begin
      run_conv(1'b0, vin[i], res, flg, lat);
      checks++; if (res !== vexp[i]) begin failures++; $display("FAIL i2f_result a=%h got=%h exp=%h", vin[i], res, vexp[i]); end
      checks++; if (flg !== 2'b00) begin failures++; $display("FAIL i2f_flags a=%h got=%b exp=00", vin[i], flg); end
      checks++; if (lat != vlat[i]) begin failures++; $display("FAIL i2f_latency a=%h got=%0d exp=%0d", vin[i], lat, vlat[i]); end
    end
  endtask

  task automatic test_f2i();
    logic [31:0] vin  [0:8];
    logic [31:0] vexp [0:8];
    int          vlat [0:8];
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
    vin  = '{32'h40200000, 32'h40600000, 32'hBFC00000, 32'h40000000, 32'h4EFFFFFF,
             32'h3F000000, 32'h3F400000, 32'h4B000000, 32'hBF800000};
    vexp = '{32'h00000002, 32'h00000004, 32'hFFFFFFFE, 32'h00000002, 32'h7FFFFF80,
             32'h00000000, 32'h00000001, 32'h00800000, 32'hFFFFFFFF};
    vlat = '{26, 26, 27, 26, 11, 28, 28, 4, 27};
    for (int i = 0; i < 9; i++) begin
      run_conv(1'b1, vin[i], res, flg, lat);
      checks++; if (res !== vexp[i]) begin failures++; $display("FAIL f2i_result a=%h got=%h exp=%h", vin[i], res, vexp[i]); end
      checks++; if (flg !== 2'b00) begin failures++; $display("FAIL f2i_flags a=%h got=%b exp=00", vin[i], flg); end
      checks++; if (lat != vlat[i]) begin failures++; $display("FAIL f2i_latency a=%h got=%0d exp=%0d", vin[i], lat, vlat[i]); end
    end
  endtask

  task automatic test_f2i_special();
    logic [31:0] vin  [0:10];
    logic [31:0] vexp [0:10];
    logic [1:0]  vflg [0:10];
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
    vin  = '{32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'h3E800000, 32'hFF800000, 32'h7F800000,
             32'h80000000, 32'h00000001, 32'h5F000000, 32'hCF000001, 32'hFFC00000};
    vexp = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
             32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    vflg = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 11; i++) begin
      run_conv(1'b1, vin[i], res, flg, lat);
      checks++; if (res !== vexp[i]) begin failures++; $display("FAIL spec_result a=%h got=%h exp=%h", vin[i], res, vexp[i]); end
      checks++; if (flg !== vflg[i]) begin failures++; $display("FAIL spec_flags a=%h got=%b exp=%b", vin[i], flg, vflg[i]); end
      checks++; if (lat != 2) begin failures++; $display("FAIL spec_latency a=%h got=%0d exp=2", vin[i], lat); end
    end
  endtask

  task automatic test_operand_hold();
    int  n;
    bit  got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'h00000001;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'b1;
    bus.a     = 32'h12345678;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", bus.busy); end
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL hold_timeout got=no_done exp=done"); end
    checks++; if (bus.result !== 32'h3F800000) begin failures++; $display("FAIL hold_result got=%h exp=3f800000", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_busy_at_done got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int e1;
    int e2;
    int bad_res;
    cnt = 0;
    e1 = -1;
    e2 = -1;
    bad_res = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'h40200000;
    @(posedge clk);
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cnt++;
        if (cnt == 1) e1 = e;
        if (cnt == 2) e2 = e;
        if (bus.result !== 32'h00000002) bad_res++;
      end
    end
    bus.start = 1'b0;
    checks++; if (cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", cnt); end
    checks++; if (e1 != 25) begin failures++; $display("FAIL b2b_first_done got=%0d exp=25", e1); end
    checks++; if (e2 != 52) begin failures++; $display("FAIL b2b_second_done got=%0d exp=52", e2); end
    checks++; if (bad_res != 0) begin failures++; $display("FAIL b2b_result got=%0d_bad exp=0_bad", bad_res); end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int          dn;
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'h00000001;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
    checks++; if (bus.flags !== 2'b00) begin failures++; $display("FAIL rstmid_flags got=%b exp=00", bus.flags); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    checks++; if (dn != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dn); end
    run_conv(1'b1, 32'h40000000, res, flg, lat);
    checks++; if (res !== 32'h00000002) begin failures++; $display("FAIL rstmid_after_result got=%h exp=2", res); end
    checks++; if (flg !== 2'b00) begin failures++; $display("FAIL rstmid_after_flags got=%b exp=00", flg); end
    checks++; if (lat != 26) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=26", lat); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'd0;
    test_reset();
    test_i2f();
    test_f2i();
    test_f2i_special();
    test_operand_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
